// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between decode and the execute-stage ALU.
//   master (decode side): drives start, a, b, funct3, funct7_5; sees result/zero/done/busy
//   slave  (ALU side)   : the reverse
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            done;
  logic            busy;

  modport master (
    output start, a, b, funct3, funct7_5,
    input  result, zero, done, busy
  );

  modport slave (
    input  start, a, b, funct3, funct7_5,
    output result, zero, done, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with start/done handshake.
//   ADD/SUB/SLT/SLTU/XOR/OR/AND finish one cycle after start is sampled.
//   SLL/SRL/SRA shift one bit per cycle; busy is high while shifting.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - alu_seq_if.slave: start, a, b, funct3, funct7_5 in;
//          result, zero, done, busy out (all registered)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; one-cycle ops and zero shifts finish here
// SHIFT | shifting r_sh one bit per cycle, r_cnt bits still to go
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } shop_t;

  state_t          r_state, w_state_nxt;
  shop_t           r_op, w_op_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;
  logic            r_zero, w_zero_nxt;
  logic            r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;
  logic [XLEN-1:0] r_sh, w_sh_nxt;
  logic [SHW-1:0]  r_cnt, w_cnt_nxt;

  logic            w_is_shift;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_slt;
  logic            w_sltu;
  logic [XLEN-1:0] w_sh_step;
  shop_t           w_req_op;

  assign w_is_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
  assign w_shamt    = bus.b[SHW-1:0];
  assign w_slt      = $signed(bus.a) < $signed(bus.b);
  assign w_sltu     = bus.a < bus.b;

  // Single-cycle result for the non-shift ops, decoded straight from the inputs
  // because these ops only ever complete on the edge that samples start.
  always_comb begin
    w_alu = '0;
    case (bus.funct3)
      3'b000:  w_alu = bus.funct7_5 ? (bus.a - bus.b) : (bus.a + bus.b);
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, w_slt};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, w_sltu};
      3'b100:  w_alu = bus.a ^ bus.b;
      3'b110:  w_alu = bus.a | bus.b;
      3'b111:  w_alu = bus.a & bus.b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_req_op = SH_SLL;
    if (bus.funct3 == 3'b101) begin
      w_req_op = bus.funct7_5 ? SH_SRA : SH_SRL;
    end
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    w_sh_step = r_sh;
    case (r_op)
      SH_SLL:  w_sh_step = {r_sh[XLEN-2:0], 1'b0};
      SH_SRL:  w_sh_step = {1'b0, r_sh[XLEN-1:1]};
      SH_SRA:  w_sh_step = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
      default: w_sh_step = r_sh;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    w_sh_nxt     = r_sh;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (!w_is_shift) begin
            w_result_nxt = w_alu;
            w_zero_nxt   = (w_alu == '0);
            w_done_nxt   = 1'b1;
          end else if (w_shamt == '0) begin
            w_result_nxt = bus.a;
            w_zero_nxt   = (bus.a == '0);
            w_done_nxt   = 1'b1;
          end else begin
            w_sh_nxt    = bus.a;
            w_cnt_nxt   = w_shamt;
            w_op_nxt    = w_req_op;
            w_busy_nxt  = 1'b1;
            w_state_nxt = SHIFT;
          end
        end
      end

      SHIFT: begin
        // Inputs (including start) are ignored here; everything needed was latched.
        w_sh_nxt  = w_sh_step;
        w_cnt_nxt = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_result_nxt = w_sh_step;
          w_zero_nxt   = (w_sh_step == '0);
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= SH_SLL;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_sh     <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_sh     <= w_sh_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.result = r_result;
  assign bus.zero   = r_zero;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an
// operator-level reference model (result, zero, latency, busy length).
module tb_alu_seq;

  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'b000:  return f7 ? a - b : a + b;
      3'b001:  return a << sh;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return f7 ? 32'($signed(a) >>> sh) : (a >> sh);
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // Called half a cycle-ish after a posedge (posedge+1). Returns at posedge+1
  // in the cycle done is high, so the next call issues back-to-back.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [31:0] exp_res;
    int          shamt;
    int          exp_lat;
    int          exp_busy;
    int          lat;
    int          busy_cnt;
    exp_res  = ref_alu(f3, f7, a, b);
    shamt    = int'(b[4:0]);
    exp_busy = ((f3 == 3'b001 || f3 == 3'b101) && shamt != 0) ? shamt : 0;
    exp_lat  = exp_busy + 1;

    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 1;
    busy_cnt  = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      if (noise) begin
        bus.start    = 1'b1;
        bus.funct3   = 3'b000;
        bus.funct7_5 = 1'b0;
        bus.a        = $urandom;
        bus.b        = 32'd1;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check_val({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    check_val({tag, "_latency"},   64'(lat), 64'(exp_lat));
    check_val({tag, "_busy_len"},  64'(busy_cnt), 64'(exp_busy));
    check_val({tag, "_busy_off"},  64'(bus.busy), 64'd0);
    check_val({tag, "_result"},    64'(bus.result), 64'(exp_res));
    check_val({tag, "_zero"},      64'(bus.zero), 64'(exp_res == 32'd0));
  endtask

  initial begin
    int dcnt;
    n_checks = 0;
    n_errors = 0;

    // Reset held two cycles with a live request on the bus.
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.a        = 32'd5;
    bus.b        = 32'd7;
    bus.funct3   = 3'b000;
    bus.funct7_5 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_val("rst_result", 64'(bus.result), 64'd0);
      check_val("rst_zero",   64'(bus.zero),   64'd1);
      check_val("rst_done",   64'(bus.done),   64'd0);
      check_val("rst_busy",   64'(bus.busy),   64'd0);
    end
    rst = 1'b0;

    // One-cycle ops, issued back-to-back.
    run_op("add_ovf", 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check_val("add_ovf_const", 64'(bus.result), 64'h8000_0000);
    run_op("sub_eq", 3'b000, 1'b1, 32'd3, 32'd3, 1'b0);
    check_val("sub_eq_const", 64'(bus.result), 64'd0);
    run_op("slt", 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_val("slt_const", 64'(bus.result), 64'd1);
    run_op("sltu", 3'b011, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_val("sltu_const", 64'(bus.result), 64'd0);
    run_op("and", 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    check_val("and_const", 64'(bus.result), 64'h00F0_00F0);
    run_op("or", 3'b110, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    check_val("or_const", 64'(bus.result), 64'hFFF0_FFF0);
    run_op("xor", 3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    check_val("xor_const", 64'(bus.result), 64'hFF00_FF00);

    // Shifts.
    run_op("sra31", 3'b101, 1'b1, 32'h8000_0000, 32'd31, 1'b0);
    check_val("sra31_const", 64'(bus.result), 64'hFFFF_FFFF);
    run_op("srl31", 3'b101, 1'b0, 32'h8000_0000, 32'd31, 1'b0);
    check_val("srl31_const", 64'(bus.result), 64'h0000_0001);
    run_op("sll0", 3'b001, 1'b0, 32'd1, 32'h20, 1'b0);
    check_val("sll0_const", 64'(bus.result), 64'd1);

    // Start pulses and operand changes during a shift must be ignored.
    run_op("srl_ign", 3'b101, 1'b0, 32'hFF, 32'd4, 1'b1);
    check_val("srl_ign_const", 64'(bus.result), 64'h0F);
    @(posedge clk); #1;
    check_val("srl_ign_single_done", 64'(bus.done), 64'd0);
    check_val("srl_ign_hold", 64'(bus.result), 64'h0F);

    // Reset in the middle of a 20-bit shift.
    dcnt         = 0;
    bus.start    = 1'b1;
    bus.funct3   = 3'b001;
    bus.funct7_5 = 1'b0;
    bus.a        = 32'd1;
    bus.b        = 32'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) dcnt++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rstmid_busy",   64'(bus.busy),   64'd0);
    check_val("rstmid_result", 64'(bus.result), 64'd0);
    for (int i = 0; i < 25; i++) begin
      if (bus.done) dcnt++;
      @(posedge clk); #1;
    end
    check_val("rstmid_no_done", 64'(dcnt), 64'd0);
    run_op("add_after_rst", 3'b000, 1'b0, 32'd2, 32'd2, 1'b0);
    check_val("add_after_rst_const", 64'(bus.result), 64'd4);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 50; i++) begin
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] ra;
      logic [31:0] rb;
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'd0;
      run_op($sformatf("rnd%0d", i), f3, f7, ra, rb, 1'b0);
    end
    @(posedge clk); #1;
    check_val("final_done_low", 64'(bus.done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
